// File: rtl/mul_share_pkg.sv
// Shared types and helpers for the round-robin multiplier share arbiter.
// Tag entries carry the requester index alongside each in-flight operation.
package mul_share_pkg;

    localparam int MAX_TAG_W = 8;

    function automatic int tag_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] index;
    } tag_t;

    function automatic int slot_lo(input int idx, input int w);
        return idx * w;
    endfunction

    function automatic int slot_hi(input int idx, input int w);
        return idx * w + w - 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the slot after the
// last winner; the pointer only moves when a grant is taken.
module rr_arbiter
    import mul_share_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = tag_w(N)
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] last_grant;

    // Descending scan so the nearest requester after last_grant wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int k = N; k >= 1; k--) begin
            int j;
            j = int'(last_grant) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                grant     = '0;
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            last_grant <= IW'(N - 1);
        end else if (advance) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one external pipelined multiplier among NUM_REQ requesters and
// parks each tagged result in that requester's slot until consumed.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 8,
    parameter int MUL_LATENCY = 1
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic [NUM_REQ-1:0]       REQ_VALID_IN,
    output logic [NUM_REQ-1:0]       REQ_READY_OUT,
    input  logic [NUM_REQ*WIDTH-1:0] REQ_A_IN,
    input  logic [NUM_REQ*WIDTH-1:0] REQ_B_IN,
    output logic [NUM_REQ-1:0]       RES_VALID_OUT,
    input  logic [NUM_REQ-1:0]       RES_READY_IN,
    output logic [NUM_REQ*WIDTH-1:0] RES_VALUE_OUT,
    output logic [WIDTH-1:0]         MUL_A_OUT,
    output logic [WIDTH-1:0]         MUL_B_OUT,
    output logic                     MUL_VALID_OUT,
    input  logic [WIDTH-1:0]         MUL_VALUE_IN,
    input  logic                     MUL_VALID_IN,
    output logic                     ERR_OUT
);

    localparam int TAG_W = tag_w(NUM_REQ);
    localparam int SW    = $clog2(MUL_LATENCY + 1);

    logic [NUM_REQ-1:0] busy;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] res_valid;
    logic [NUM_REQ-1:0] res_set;
    logic [NUM_REQ-1:0] consume;
    logic [TAG_W-1:0]   grant_idx;
    logic [TAG_W-1:0]   tail_idx;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic [WIDTH-1:0]   slot [NUM_REQ];
    logic [SW-1:0]      settle;
    logic               settled;
    logic               hs;
    logic               err_set;
    tag_t               issue_tag;
    tag_t               tag_pipe [MUL_LATENCY];
    tag_t               tail;

    assign eligible = REQ_VALID_IN & ~busy & {NUM_REQ{RSTN}};

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (TAG_W)
    ) u_arb (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .req       (eligible),
        .advance   (hs),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign REQ_READY_OUT = grant;
    assign hs            = |(grant & REQ_VALID_IN);
    assign a_sel         = REQ_A_IN[slot_lo(int'(grant_idx), WIDTH) +: WIDTH];
    assign b_sel         = REQ_B_IN[slot_lo(int'(grant_idx), WIDTH) +: WIDTH];

    assign tail     = tag_pipe[MUL_LATENCY-1];
    assign tail_idx = tail.index[TAG_W-1:0];
    assign settled  = (settle == SW'(MUL_LATENCY));
    assign consume  = res_valid & RES_READY_IN;

    // Strobes before the pipeline refills after reset are stale, not errors.
    assign err_set  = MUL_VALID_IN & ~tail.valid & settled;

    always_comb begin
        res_set = '0;
        if (MUL_VALID_IN && tail.valid) begin
            res_set[tail_idx] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            busy          <= '0;
            res_valid     <= '0;
            MUL_A_OUT     <= '0;
            MUL_B_OUT     <= '0;
            MUL_VALID_OUT <= 1'b0;
            ERR_OUT       <= 1'b0;
            issue_tag     <= '0;
            settle        <= '0;
        end else begin
            busy          <= (busy & ~consume) | grant;
            res_valid     <= (res_valid & ~consume) | res_set;
            MUL_VALID_OUT <= hs;
            if (hs) begin
                MUL_A_OUT <= a_sel;
                MUL_B_OUT <= b_sel;
            end
            issue_tag.valid <= hs;
            issue_tag.index <= MAX_TAG_W'(grant_idx);
            if (!settled) begin
                settle <= settle + 1'b1;
            end
            if (err_set) begin
                ERR_OUT <= 1'b1;
            end
        end
    end

    // issue_tag lines up with MUL_VALID_OUT; the tail meets MUL_VALID_IN.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            for (int s = 0; s < MUL_LATENCY; s++) begin
                tag_pipe[s] <= '0;
            end
        end else begin
            tag_pipe[0] <= issue_tag;
            for (int s = 1; s < MUL_LATENCY; s++) begin
                tag_pipe[s] <= tag_pipe[s-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                slot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (res_set[i]) begin
                    slot[i] <= MUL_VALUE_IN;
                end
            end
        end
    end

    always_comb begin
        RES_VALUE_OUT = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            RES_VALUE_OUT[slot_lo(i, WIDTH) +: WIDTH] = slot[i];
        end
    end

    assign RES_VALID_OUT = res_valid;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Testbench for mul_share_arbiter with an attached Q.3 fixed-point multiplier
// and a scoreboard of expected products per requester.
module tb_mul_share_arbiter;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int L    = 1;
    localparam int FRAC = 3;

    logic           CLK = 1'b0;
    logic           RSTN;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   res_valid;
    logic [N-1:0]   res_ready;
    logic [N*W-1:0] res_value;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic           mul_valid_out;
    logic [W-1:0]   mul_value;
    logic           mul_valid_in;
    logic           err;
    logic           mul_inj;
    logic [W-1:0]   inj_val;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] exp_q [N][$];

    always #5 CLK = ~CLK;

    mul_share_arbiter #(
        .NUM_REQ     (N),
        .WIDTH       (W),
        .MUL_LATENCY (L)
    ) dut (
        .CLK           (CLK),
        .RSTN          (RSTN),
        .REQ_VALID_IN  (req_valid),
        .REQ_READY_OUT (req_ready),
        .REQ_A_IN      (req_a),
        .REQ_B_IN      (req_b),
        .RES_VALID_OUT (res_valid),
        .RES_READY_IN  (res_ready),
        .RES_VALUE_OUT (res_value),
        .MUL_A_OUT     (mul_a),
        .MUL_B_OUT     (mul_b),
        .MUL_VALID_OUT (mul_valid_out),
        .MUL_VALUE_IN  (mul_value),
        .MUL_VALID_IN  (mul_valid_in),
        .ERR_OUT       (err)
    );

    function automatic logic [W-1:0] fx(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = $signed(a) * $signed(b);
        p = p >>> FRAC;
        return p[W-1:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // External multiplier, latency L, not reset
    logic [L-1:0] pv = '0;
    logic [W-1:0] pd [L];

    always @(posedge CLK) begin
        for (int s = L - 1; s > 0; s--) begin
            pv[s] <= pv[s-1];
            pd[s] <= pd[s-1];
        end
        pv[0] <= mul_valid_out;
        pd[0] <= fx(mul_a, mul_b);
    end

    assign mul_valid_in = pv[L-1] | mul_inj;
    assign mul_value    = mul_inj ? inj_val : pd[L-1];

    // Reference model: busy flags, rotating pointer, result due times
    logic [N-1:0] mbusy = '0;
    int           mlast = N - 1;
    longint       gc [N];
    logic         mprev = 1'b0;
    logic         merr  = 1'b0;
    int           guard = L;
    longint       cyc   = 0;

    always @(negedge CLK) begin
        logic [N-1:0] rv_exp;
        logic [N-1:0] gexp;
        int           gj;
        cyc++;
        if (!RSTN) begin
            check("ready_in_reset", 64'(req_ready), 64'(0));
            mbusy = '0;
            mlast = N - 1;
            mprev = 1'b0;
            merr  = 1'b0;
            guard = L;
            for (int i = 0; i < N; i++) begin
                exp_q[i].delete();
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                rv_exp[i] = mbusy[i] && (cyc >= gc[i] + 2 + L);
            end
            check("res_valid", 64'(res_valid), 64'(rv_exp));
            check("mul_valid", 64'(mul_valid_out), 64'(mprev));
            check("err", 64'(err), 64'(merr));
            gexp = '0;
            gj   = 0;
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (mlast + k) % N;
                if (gexp == '0 && req_valid[j] && !mbusy[j]) begin
                    gexp[j] = 1'b1;
                    gj      = j;
                end
            end
            check("grant", 64'(req_ready), 64'(gexp));
            if (gexp != '0) begin
                exp_q[gj].push_back(fx(req_a[gj*W +: W], req_b[gj*W +: W]));
                gc[gj] = cyc;
                mlast  = gj;
            end
            mprev = (gexp != '0);
            if (mul_inj && guard == 0) begin
                merr = 1'b1;
            end
            if (guard > 0) begin
                guard--;
            end
            mbusy = (mbusy & ~(rv_exp & res_ready)) | gexp;
        end
    end

    // Monitor: pop on each result handshake
    always @(negedge CLK) begin
        if (RSTN) begin
            for (int i = 0; i < N; i++) begin
                if (res_valid[i] && res_ready[i]) begin
                    if (exp_q[i].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL result_%0d: got %0h expected none", i, res_value[i*W +: W]);
                    end else begin
                        logic [W-1:0] e;
                        e = exp_q[i].pop_front();
                        check($sformatf("result_%0d", i), 64'(res_value[i*W +: W]), 64'(e));
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = W'($urandom);
            req_b[i*W +: W] = W'($urandom);
        end
    endtask

    initial begin
        RSTN      = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = '0;
        mul_inj   = 1'b0;
        inj_val   = '0;
        step(3);
        @(negedge CLK);
        check("rst_res_valid", 64'(res_valid), 64'(0));
        check("rst_res_value", 64'(res_value), 64'(0));
        check("rst_mul_a", 64'({mul_a, mul_b}), 64'(0));
        check("rst_mul_valid", 64'(mul_valid_out), 64'(0));
        check("rst_err", 64'(err), 64'(0));

        // Single request 0x0C * 0x10 -> 0x18 three cycles later
        step(1);
        RSTN          = 1'b1;
        req_valid     = 4'b0001;
        req_a[7:0]    = 8'h0C;
        req_b[7:0]    = 8'h10;
        res_ready     = '1;
        step(1);
        req_valid = '0;
        step(2);
        @(negedge CLK);
        check("first_valid", 64'(res_valid[0]), 64'(1));
        check("first_value", 64'(res_value[7:0]), 64'(8'h18));
        step(3);

        // All requesters continuously valid with distinct operands
        req_a     = {8'h03, 8'h20, 8'hF8, 8'h0C};
        req_b     = {8'h40, 8'hF0, 8'h10, 8'h08};
        req_valid = '1;
        res_ready = '1;
        step(16);

        // Requester 2 withholds consume for 10 cycles
        res_ready = 4'b1011;
        step(10);
        res_ready = '1;
        step(8);

        // Only requesters 1 and 3
        req_valid = 4'b0010;
        step(1);
        req_valid = 4'b1010;
        step(12);

        // Randomized traffic
        for (int c = 0; c < 300; c++) begin
            req_valid = N'($urandom);
            rand_ops();
            for (int i = 0; i < N; i++) begin
                res_ready[i] = ($urandom_range(0, 9) < 7);
            end
            step(1);
        end

        // Stray multiplier strobe with nothing outstanding
        req_valid = '0;
        res_ready = '1;
        step(6);
        mul_inj = 1'b1;
        inj_val = 8'h5A;
        step(1);
        mul_inj = 1'b0;
        step(5);
        @(negedge CLK);
        check("err_sticky", 64'(err), 64'(1));
        check("err_no_slot", 64'(res_valid), 64'(0));

        // Reset with results in flight
        req_valid = '1;
        res_ready = '0;
        rand_ops();
        step(4);
        RSTN      = 1'b0;
        res_ready = '0;
        step(1);
        RSTN      = 1'b1;
        res_ready = '1;
        @(negedge CLK);
        check("post_rst_grant", 64'(req_ready), 64'(4'b0001));
        check("post_rst_err", 64'(err), 64'(0));
        step(12);
        req_valid = '0;
        step(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
